// File: rtl/tpu_seq_if.sv
// Instruction handshake and array/memory control bundle for the TPU sequencer.
// The master side issues instructions; the slave side is the sequencer itself.
interface tpu_seq_if #(
  parameter int AW = 12
);
  logic          instr_valid;
  logic [15:0]   instr;
  logic          instr_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic          w_load;
  logic          a_valid;
  logic          acc_capture;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output instr_valid, instr,
    input  instr_ready, mem_addr, mem_rd, mem_wr, w_load, a_valid,
           acc_capture, busy, done, err
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, mem_addr, mem_rd, mem_wr, w_load, a_valid,
           acc_capture, busy, done, err
  );
endinterface

// File: rtl/tpu_seq.sv
// Instruction sequencer for an NxN systolic array: weight load, activation
// streaming with pipeline drain, and result store, one instruction at a time.
module tpu_seq #(
  parameter int N  = 4,
  parameter int AW = 12
) (
  input  logic      clk,
  input  logic      rst,
  tpu_seq_if.slave  bus
);

  localparam int KW = $clog2(2 * N);
  localparam logic [KW-1:0] K_LAST_BEAT  = KW'(N - 1);
  localparam logic [KW-1:0] K_LAST_DRAIN = KW'(2 * N - 2);

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOADW  = 4'h1;
  localparam logic [3:0] OP_MATMUL = 4'h2;
  localparam logic [3:0] OP_STORE  = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_STORE
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] last_addr_q;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rdy_q;

  logic          instr_ready;
  logic          accept;
  logic          strobe;
  logic [AW-1:0] beat_addr;
  logic [AW-1:0] mem_addr;
  logic [3:0]    opcode;

  // rdy_q keeps instr_ready low while reset is held and rises on the first edge after.
  assign instr_ready = rdy_q && (state_q == S_IDLE);
  assign accept      = bus.instr_valid && instr_ready;
  assign opcode      = bus.instr[15:12];
  assign strobe      = (state_q == S_WLOAD) || (state_q == S_STREAM) || (state_q == S_STORE);
  assign beat_addr   = base_q + AW'(k_q);
  assign mem_addr    = strobe ? beat_addr : last_addr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      base_q      <= '0;
      last_addr_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (strobe) last_addr_q <= beat_addr;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          k_d    = '0;
          base_d = bus.instr[AW-1:0];
          case (opcode)
            OP_NOP:    done_d  = 1'b1;
            OP_LOADW:  state_d = S_WLOAD;
            OP_MATMUL: state_d = S_STREAM;
            OP_STORE:  state_d = S_STORE;
            default:   err_d   = 1'b1;
          endcase
        end
      end
      S_WLOAD, S_STORE: begin
        if (k_q == K_LAST_BEAT) begin
          state_d = S_IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_STREAM: begin
        if (k_q == K_LAST_BEAT) begin
          state_d = S_DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        // Partial sums need 2N-1 cycles to ripple out of the array.
        if (k_q == K_LAST_DRAIN) begin
          state_d = S_IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  assign bus.instr_ready = instr_ready;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_rd      = (state_q == S_WLOAD) || (state_q == S_STREAM);
  assign bus.mem_wr      = (state_q == S_STORE);
  assign bus.w_load      = (state_q == S_WLOAD);
  assign bus.a_valid     = (state_q == S_STREAM);
  assign bus.acc_capture = (state_q == S_DRAIN) && (k_q == K_LAST_DRAIN);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_tpu_seq.sv
// Scoreboard bench for tpu_seq: each issued instruction pushes its expected
// per-cycle output trace, and every clock the front entry is compared.
module tb_tpu_seq;

  localparam int N  = 4;
  localparam int AW = 12;

  // flag bit order: ready busy done rd wr wload avalid capture
  localparam logic [7:0] F_IDLE   = 8'b1000_0000;
  localparam logic [7:0] F_DONE   = 8'b1010_0000;
  localparam logic [7:0] F_WLOAD  = 8'b0101_0100;
  localparam logic [7:0] F_STREAM = 8'b0101_0010;
  localparam logic [7:0] F_DRAIN  = 8'b0100_0000;
  localparam logic [7:0] F_CAPT   = 8'b0100_0001;
  localparam logic [7:0] F_STORE  = 8'b0100_1000;

  typedef struct {
    logic [7:0]    flags;
    logic          addr_chk;
    logic [AW-1:0] addr;
    logic          set_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tpu_seq_if #(.AW(AW)) bus ();

  tpu_seq #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            vectors     = 0;
  int            miscompares = 0;
  exp_t          sb[$];
  logic [AW-1:0] exp_last    = '0;
  logic          exp_err     = 1'b0;
  logic          last_done   = 1'b0;

  function automatic exp_t ent(input logic [7:0] f, input logic ac,
                               input logic [AW-1:0] a, input logic se);
    exp_t e;
    e.flags    = f;
    e.addr_chk = ac;
    e.addr     = a;
    e.set_err  = se;
    return e;
  endfunction

  function automatic logic [7:0] observed();
    return {bus.instr_ready, bus.busy, bus.done, bus.mem_rd, bus.mem_wr,
            bus.w_load, bus.a_valid, bus.acc_capture};
  endfunction

  // Called at posedge+1; samples mid-cycle, then returns at the next posedge+1.
  task automatic cycle(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) e = sb.pop_front();
    else               e = ent(F_IDLE, 1'b0, '0, 1'b0);
    if (e.set_err)  exp_err  = 1'b1;
    if (e.addr_chk) exp_last = e.addr;
    last_done = bus.done;
    vectors++;
    if (observed() !== e.flags) begin
      miscompares++;
      $display("FAIL %s flags got %b want %b (rdy busy done rd wr wl av cap) t=%0t",
               tag, observed(), e.flags, $time);
    end
    vectors++;
    if (bus.mem_addr !== exp_last) begin
      miscompares++;
      $display("FAIL %s mem_addr got %h want %h t=%0t", tag, bus.mem_addr, exp_last, $time);
    end
    vectors++;
    if (bus.err !== exp_err) begin
      miscompares++;
      $display("FAIL %s err got %b want %b t=%0t", tag, bus.err, exp_err, $time);
    end
    vectors++;
    if (((bus.mem_rd & bus.mem_wr) | (bus.w_load & bus.a_valid)) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s strobe_overlap got rd=%b wr=%b wl=%b av=%b want no overlap",
               tag, bus.mem_rd, bus.mem_wr, bus.w_load, bus.a_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [3:0] op, input logic [AW-1:0] base);
    case (op)
      4'h0: sb.push_back(ent(F_DONE, 1'b0, '0, 1'b0));
      4'h1: begin
        for (int k = 0; k < N; k++) sb.push_back(ent(F_WLOAD, 1'b1, AW'(base + k), 1'b0));
        sb.push_back(ent(F_DONE, 1'b0, '0, 1'b0));
      end
      4'h2: begin
        for (int k = 0; k < N; k++) sb.push_back(ent(F_STREAM, 1'b1, AW'(base + k), 1'b0));
        for (int d = 0; d < 2 * N - 1; d++)
          sb.push_back(ent((d == 2 * N - 2) ? F_CAPT : F_DRAIN, 1'b0, '0, 1'b0));
        sb.push_back(ent(F_DONE, 1'b0, '0, 1'b0));
      end
      4'h3: begin
        for (int k = 0; k < N; k++) sb.push_back(ent(F_STORE, 1'b1, AW'(base + k), 1'b0));
        sb.push_back(ent(F_DONE, 1'b0, '0, 1'b0));
      end
      default: sb.push_back(ent(F_IDLE, 1'b0, '0, 1'b1));
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] base);
    for (int g = 0; g < 200 && sb.size() > 1; g++) cycle("drain");
    bus.instr_valid = 1'b1;
    bus.instr       = {op, 4'(0), base} | 16'(0);
    bus.instr       = {op, 12'(base)};
    if (sb.size() == 0) sb.push_back(ent(F_IDLE, 1'b0, '0, 1'b0));
    push_seq(op, base);
    cycle("accept");
    bus.instr_valid = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cycle("run");
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if (observed() !== 8'h00 || bus.mem_addr !== '0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got flags=%b addr=%h err=%b want all zero",
               tag, observed(), bus.mem_addr, bus.err);
    end
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h1005;
    @(negedge clk);
    check_all_zero("reset_ignores_valid");
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release instr_ready got %b want 1", bus.instr_ready);
    end
    exp_last = '0;
    exp_err  = 1'b0;
    run_idle(2);
  endtask

  task automatic test_nop();
    issue(4'h0, 12'h0AB);
    run_idle(2);
  endtask

  task automatic test_loadw();
    issue(4'h1, 12'h010);
    run_idle(6);
  endtask

  task automatic test_matmul();
    int lat;
    issue(4'h2, 12'h020);
    lat = 0;
    last_done = 1'b0;
    for (int g = 0; g < 40 && !last_done; g++) begin
      cycle("matmul");
      lat++;
    end
    vectors++;
    if (lat !== 3 * N) begin
      miscompares++;
      $display("FAIL matmul_latency got %0d want %0d", lat, 3 * N);
    end
    run_idle(2);
  endtask

  task automatic test_store_wrap();
    issue(4'h3, 12'hFFE);
    run_idle(7);
  endtask

  task automatic test_back_to_back();
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h1040;
    if (sb.size() == 0) sb.push_back(ent(F_IDLE, 1'b0, '0, 1'b0));
    push_seq(4'h1, 12'h040);
    cycle("b2b_accept1");
    bus.instr = 16'h2080;
    for (int g = 0; g < 50 && sb.size() > 1; g++) cycle("b2b_wload");
    push_seq(4'h2, 12'h080);
    cycle("b2b_accept2");
    bus.instr_valid = 1'b0;
    run_idle(3 * N + 2);
  endtask

  task automatic test_illegal();
    issue(4'h7, 12'h123);
    run_idle(3);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_err got %b want 1", bus.err);
    end
    issue(4'h0, 12'h000);
    run_idle(2);
    vectors++;
    if (bus.err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got %b want 1", bus.err);
    end
  endtask

  task automatic test_reset_mid();
    issue(4'h2, 12'h200);
    cycle("stream1");
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("reset_mid_async");
    sb.delete();
    exp_last = '0;
    exp_err  = 1'b0;
    @(negedge clk);
    check_all_zero("reset_mid_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready got %b want 1", bus.instr_ready);
    end
    run_idle(2 * N);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nop();
    test_loadw();
    test_matmul();
    test_store_wrap();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tpu_seq.md
TPU_SEQ -- requirements
Module: tpu_seq

Interface
REQ-001 Parameter N, default 4: systolic array dimension, legal range 2..16.
REQ-002 Parameter AW, default 12: memory address width; instruction address field is instr[AW-1:0], and AW SHALL be at most 12.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset; rst=0 SHALL force reset state immediately, independent of clk.
REQ-005 instr_valid  input  1: instruction offered this cycle.
REQ-006 instr  input  16: [15:12] opcode, [11:0] base address.
REQ-007 instr_ready  output  1: sequencer can accept an instruction.
REQ-008 mem_addr  output  AW: memory address for the current beat.
REQ-009 mem_rd  output  1: memory read strobe.
REQ-010 mem_wr  output  1: memory write strobe.
REQ-011 w_load  output  1: array weight-shift enable.
REQ-012 a_valid  output  1: activation beat valid into the array.
REQ-013 acc_capture  output  1: array result capture strobe.
REQ-014 busy  output  1: an instruction is executing.
REQ-015 done  output  1: one-cycle completion pulse.
REQ-016 err  output  1: sticky illegal-opcode flag.

Function
REQ-017 FSM states SHALL be IDLE, WLOAD, STREAM, DRAIN and STORE; all outputs SHALL be registered or decoded from registered state only, with no combinational path from instr or instr_valid.
REQ-018 instr_ready SHALL equal 1 only in IDLE, and accept SHALL occur exactly when instr_valid && instr_ready; instr_valid outside IDLE SHALL be ignored.
REQ-019 On accept, the sequencer SHALL latch the base address and clear the beat counter k; execution starts the next cycle.
REQ-020 Opcode 0x0 (NOP) SHALL stay in IDLE and pulse done the cycle after accept.
REQ-021 Opcode 0x1 (LOADW) SHALL run WLOAD for N cycles with mem_rd=1, w_load=1 and mem_addr=base+k for k=0..N-1, then go to IDLE.
REQ-022 Opcode 0x2 (MATMUL) SHALL run STREAM for N cycles with mem_rd=1, a_valid=1 and mem_addr=base+k.
REQ-023 After STREAM, the sequencer SHALL run DRAIN for 2N-1 cycles with mem_rd=0, a_valid=0 and acc_capture=1 on the final DRAIN cycle only, then go to IDLE.
REQ-024 Opcode 0x3 (STORE) SHALL run STORE for N cycles with mem_wr=1 and mem_addr=base+k, then go to IDLE.
REQ-025 Opcodes 0x4..0xF SHALL set err=1, keep the FSM in IDLE and suppress done; err SHALL clear only on reset.
REQ-026 mem_addr SHALL wrap modulo 2^AW (base+k truncated to AW bits).
REQ-027 When no strobe is active, mem_addr SHALL hold its last value.
REQ-028 busy SHALL equal 1 in every state except IDLE.
REQ-029 done SHALL pulse for exactly one cycle, in the first IDLE cycle after LOADW, MATMUL or STORE completes.
REQ-030 A new instruction SHALL be acceptable in that same done cycle, giving back-to-back issue with zero bubble.
REQ-031 mem_rd and mem_wr SHALL never be 1 in the same cycle, and w_load and a_valid SHALL never be 1 in the same cycle.
REQ-032 Instruction latency from accept to done SHALL be N+1 cycles for LOADW and STORE, 3N for MATMUL, and 1 for NOP.

Reset
REQ-033 While rst=0, the FSM SHALL be IDLE, k=0, and mem_addr, mem_rd, mem_wr, w_load, a_valid, acc_capture, busy, done and err SHALL all be 0, with instr_ready=0.
REQ-034 After rst deasserts, instr_ready SHALL be 1 on the first rising clk edge.
REQ-035 Reset asserted mid-instruction SHALL abort it immediately with no done pulse, and no strobe SHALL remain active.

Verification (N=4, AW=12)
REQ-036 LOADW base 0x010 -> w_load and mem_rd high for 4 cycles, mem_addr 0x010..0x013, done 5 cycles after accept.
REQ-037 MATMUL base 0x020 -> a_valid high for 4 cycles at 0x020..0x023, 7 DRAIN cycles, acc_capture on DRAIN cycle 7, done 12 cycles after accept.
REQ-038 STORE base 0xFFE -> mem_wr high for 4 cycles, mem_addr 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 LOADW immediately followed by MATMUL with instr_valid held high -> second accept in the done cycle, w_load and a_valid never overlap.
REQ-040 Opcode 0x7 -> err=1, no done, and err persists through a later NOP, which does pulse done.
REQ-041 rst=0 on STREAM cycle 2 -> all outputs 0 asynchronously, and after release instr_ready=1 with no done pulse.
